// File: rtl/preem_subframe_buffer.sv
// Ping-pong subframe buffer between pre-emphasis and LPC analysis: two banks of
// SUBFRAME_LEN samples, one filling while the other is read through a random-access port.
module preem_subframe_buffer #(
  parameter int DATA_W       = 17,
  parameter int SUBFRAME_LEN = 40,
  parameter int ADDR_W       = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     new_subframe,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic        [ADDR_W-1:0] rd_addr,
  input  logic                     rd_en,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     bank_ready,
  input  logic                     bank_release,
  output logic                     frame_done,
  output logic                     overflow
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SUBFRAME_LEN - 1);
  localparam logic [ADDR_W:0]   LEN_EXT  = (ADDR_W + 1)'(SUBFRAME_LEN);

  logic signed [DATA_W-1:0] mem_q [2][SUBFRAME_LEN];

  logic                     wr_bank_q, wr_bank_d;
  logic        [ADDR_W-1:0] wr_idx_q, wr_idx_d;
  logic                     rd_bank_q, rd_bank_d;
  logic        [1:0]        bank_full_q, bank_full_d;
  logic                     bank_ready_q, bank_ready_d;
  logic                     frame_done_q, frame_done_d;
  logic                     overflow_q, overflow_d;
  logic signed [DATA_W-1:0] rd_data_q, rd_data_d;
  logic                     mem_we;
  logic        [ADDR_W-1:0] mem_waddr;

  always_comb begin
    wr_bank_d    = wr_bank_q;
    wr_idx_d     = wr_idx_q;
    rd_bank_d    = rd_bank_q;
    bank_full_d  = bank_full_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    rd_data_d    = rd_data_q;
    mem_we       = 1'b0;
    mem_waddr    = wr_idx_q;

    if (new_subframe) begin
      // Restart discards the partial subframe; a coincident sample becomes index 0.
      wr_idx_d = '0;
      if (sample_valid) begin
        mem_we    = 1'b1;
        mem_waddr = '0;
        wr_idx_d  = ADDR_W'(1);
      end
    end else if (sample_valid) begin
      if (!bank_full_q[wr_bank_q]) begin
        mem_we = 1'b1;
        if (wr_idx_q == LAST_IDX) begin
          bank_full_d[wr_bank_q] = 1'b1;
          wr_bank_d              = ~wr_bank_q;
          wr_idx_d               = '0;
          frame_done_d           = 1'b1;
        end else begin
          wr_idx_d = wr_idx_q + 1'b1;
        end
      end else begin
        overflow_d = 1'b1;
      end
    end

    // Release never targets the bank a write can complete into, so both may apply.
    if (bank_release && bank_ready_q) begin
      bank_full_d[rd_bank_q] = 1'b0;
      rd_bank_d              = ~rd_bank_q;
    end

    if (rd_en) begin
      if ({1'b0, rd_addr} < LEN_EXT) rd_data_d = mem_q[rd_bank_q][rd_addr];
      else                           rd_data_d = '0;
    end

    bank_ready_d = bank_full_d[rd_bank_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q    <= 1'b0;
      wr_idx_q     <= '0;
      rd_bank_q    <= 1'b0;
      bank_full_q  <= '0;
      bank_ready_q <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      wr_bank_q    <= wr_bank_d;
      wr_idx_q     <= wr_idx_d;
      rd_bank_q    <= rd_bank_d;
      bank_full_q  <= bank_full_d;
      bank_ready_q <= bank_ready_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Sample storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_bank_q][mem_waddr] <= sample_in;
  end

  assign rd_data    = rd_data_q;
  assign bank_ready = bank_ready_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule
